// File: rtl/clock_pkg.sv
// Shared constants for the digital clock controller: mode encoding,
// default timing values and a counter-width helper.
package clock_pkg;

  localparam logic [1:0] MODE_RUN      = 2'd0;
  localparam logic [1:0] MODE_SET_HOUR = 2'd1;
  localparam logic [1:0] MODE_SET_MIN  = 2'd2;

  localparam int DEF_CLK_HZ       = 1000;
  localparam int DEF_DEBOUNCE_CYC = 20;
  localparam int DEF_REPEAT_DLY   = 500;
  localparam int DEF_REPEAT_CYC   = 200;
  localparam int DEF_BLINK_HALF   = 250;

  typedef enum logic [1:0] {
    ST_RUN      = MODE_RUN,
    ST_SET_HOUR = MODE_SET_HOUR,
    ST_SET_MIN  = MODE_SET_MIN
  } state_e;

  // Bits needed to hold the values 0..n-1 (never narrower than one bit).
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Front-panel key conditioner: 2-flop synchronizer, stability counter,
// debounced level and a one-cycle press pulse on each accepted 0->1 change.
module key_debounce
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic level,
  output logic press
);

  localparam int            CW       = cnt_w(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_TERM = CW'(DEBOUNCE_CYC - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
      press <= 1'b0;
      // Any sample that agrees with the current level restarts the count.
      if (sync2 != level) begin
        if (cnt == CNT_TERM) begin
          level <= sync2;
          press <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Digital clock mode/timing controller: 1 Hz prescaler, RUN/SET_HOUR/SET_MIN
// sequencing, minute/hour adjust pulses with auto-repeat, and set-field blink.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int CLK_HZ       = DEF_CLK_HZ,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int REPEAT_DLY   = DEF_REPEAT_DLY,
  parameter int REPEAT_CYC   = DEF_REPEAT_CYC,
  parameter int BLINK_HALF   = DEF_BLINK_HALF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_mode,
  input  logic       key_inc,
  output logic       tick_1hz,
  output logic       sec_clr,
  output logic       adj_min,
  output logic       adj_hour,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int PW = cnt_w(CLK_HZ);
  localparam int RW = cnt_w(REPEAT_DLY);
  localparam int BW = cnt_w(BLINK_HALF);

  localparam logic [PW-1:0] PRESC_TERM = PW'(CLK_HZ - 1);
  localparam logic [RW-1:0] REP_TERM   = RW'(REPEAT_DLY - 1);
  localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_DLY - REPEAT_CYC);
  localparam logic [BW-1:0] BLINK_TERM = BW'(BLINK_HALF - 1);

  state_e        state;
  logic [PW-1:0] presc;
  logic [RW-1:0] rep_cnt;
  logic          rep_active;
  logic [BW-1:0] blink_cnt;

  logic unused_mode_level;
  logic mode_press;
  logic inc_level;
  logic inc_press;
  logic inc_pulse;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_mode (
    .clk     (clk),
    .rst     (rst),
    .key_raw (key_mode),
    .level   (unused_mode_level),
    .press   (mode_press)
  );

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_inc (
    .clk     (clk),
    .rst     (rst),
    .key_raw (key_inc),
    .level   (inc_level),
    .press   (inc_press)
  );

  // A fresh press always adjusts; a held key adjusts each time the repeat counter hits terminal.
  assign inc_pulse = inc_press | (rep_active & inc_level & (rep_cnt == REP_TERM));
  assign mode      = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      presc      <= '0;
      rep_cnt    <= '0;
      rep_active <= 1'b0;
      blink_cnt  <= '0;
      blink      <= 1'b0;
      tick_1hz   <= 1'b0;
      sec_clr    <= 1'b0;
      adj_min    <= 1'b0;
      adj_hour   <= 1'b0;
    end else begin
      tick_1hz <= 1'b0;
      sec_clr  <= 1'b0;
      adj_min  <= 1'b0;
      adj_hour <= 1'b0;
      if (mode_press) begin
        // A mode change wins over a coincident inc press and resets every per-state counter.
        presc      <= '0;
        rep_cnt    <= '0;
        rep_active <= 1'b0;
        blink_cnt  <= '0;
        blink      <= 1'b0;
        case (state)
          ST_RUN: begin
            state   <= ST_SET_HOUR;
            sec_clr <= 1'b1;
          end
          ST_SET_HOUR: state <= ST_SET_MIN;
          default:     state <= ST_RUN;
        endcase
      end else if (state == ST_RUN) begin
        rep_cnt    <= '0;
        rep_active <= 1'b0;
        blink_cnt  <= '0;
        blink      <= 1'b0;
        if (presc == PRESC_TERM) begin
          presc    <= '0;
          tick_1hz <= 1'b1;
        end else begin
          presc <= presc + PW'(1);
        end
      end else begin
        presc <= '0;
        if (blink_cnt == BLINK_TERM) begin
          blink_cnt <= '0;
          blink     <= ~blink;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
        adj_hour <= inc_pulse & (state == ST_SET_HOUR);
        adj_min  <= inc_pulse & (state == ST_SET_MIN);
        if (inc_press) begin
          rep_active <= 1'b1;
          rep_cnt    <= '0;
        end else if (rep_active && inc_level) begin
          if (rep_cnt == REP_TERM) rep_cnt <= REP_RELOAD;
          else                     rep_cnt <= rep_cnt + RW'(1);
        end else begin
          rep_active <= 1'b0;
          rep_cnt    <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed key sequences, an event-level reference
// model compared every cycle, and literal checks on pulse timing.
module tb_clock_set_ctrl;

  localparam int CLK_HZ = 10;
  localparam int DC     = 4;
  localparam int RD     = 20;
  localparam int RC     = 5;
  localparam int BH     = 3;
  localparam int W      = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_mode = 1'b0;
  logic       key_inc = 1'b0;
  logic       tick_1hz, sec_clr, adj_min, adj_hour, blink;
  logic [1:0] mode;

  clock_set_ctrl #(
    .CLK_HZ(CLK_HZ), .DEBOUNCE_CYC(DC), .REPEAT_DLY(RD), .REPEAT_CYC(RC), .BLINK_HALF(BH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_mode (key_mode),
    .key_inc  (key_inc),
    .tick_1hz (tick_1hz),
    .sec_clr  (sec_clr),
    .adj_min  (adj_min),
    .adj_hour (adj_hour),
    .mode     (mode),
    .blink    (blink)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Keys: a two-edge delay, then a run of DC samples differing from the level flips it.
  // FSM: counts edges since entering the current state and derives outputs arithmetically.
  logic [W-1:0] exp_q[$];
  bit           m_valid = 0;
  logic [1:0]   m_mode = 2'd0;
  int           m_since = 0;
  int           m_rep_age = 0;
  bit           m_rep_on = 0;
  bit           m_blink = 0;
  bit           d1[2], d2[2], lvl[2], prs[2];
  int           streak[2];

  always @(posedge clk) begin : model
    bit raw[2];
    bit mp, ip, il, t, c, amin, ahr, s;
    raw[0] = key_mode;
    raw[1] = key_inc;
    t = 0; c = 0; amin = 0; ahr = 0;
    if (rst) begin
      m_valid = 1; m_mode = 2'd0; m_since = 0; m_rep_on = 0; m_rep_age = 0; m_blink = 0;
      for (int k = 0; k < 2; k++) begin
        d1[k] = 0; d2[k] = 0; lvl[k] = 0; prs[k] = 0; streak[k] = 0;
      end
    end else begin
      mp = prs[0]; ip = prs[1]; il = lvl[1];
      if (mp) begin
        if (m_mode == 2'd0) c = 1;
        m_mode = (m_mode == 2'd2) ? 2'd0 : m_mode + 2'd1;
        m_since = 0; m_rep_on = 0; m_rep_age = 0; m_blink = 0;
      end else begin
        m_since++;
        if (m_mode == 2'd0) begin
          t = (m_since % CLK_HZ) == 0;
          m_blink = 0; m_rep_on = 0;
        end else begin
          m_blink = ((m_since / BH) % 2) == 1;
          if (ip) begin
            m_rep_on = 1; m_rep_age = 0;
            if (m_mode == 2'd1) ahr = 1; else amin = 1;
          end else if (m_rep_on && il) begin
            m_rep_age++;
            if (m_rep_age >= RD && ((m_rep_age - RD) % RC) == 0) begin
              if (m_mode == 2'd1) ahr = 1; else amin = 1;
            end
          end else begin
            m_rep_on = 0;
          end
        end
      end
      for (int k = 0; k < 2; k++) begin
        s = d2[k]; d2[k] = d1[k]; d1[k] = raw[k]; prs[k] = 0;
        if (s != lvl[k]) begin
          streak[k]++;
          if (streak[k] == DC) begin
            lvl[k] = s; prs[k] = s; streak[k] = 0;
          end
        end else begin
          streak[k] = 0;
        end
      end
    end
    if (m_valid) exp_q.push_back({t, c, amin, ahr, m_mode, m_blink});
  end

  // ---------------- scoreboard / monitor ----------------
  int         tick_log[$], clr_log[$], amin_log[$], ahour_log[$], mchg_log[$];
  logic [1:0] prev_mode = 2'd0;

  always @(posedge clk) begin : compare
    logic [W-1:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("outputs{tick,clr,min,hour,mode,blink}",
            {25'd0, tick_1hz, sec_clr, adj_min, adj_hour, mode, blink}, {25'd0, e});
    end
    if (!rst) begin
      if (tick_1hz) tick_log.push_back(cyc);
      if (sec_clr)  clr_log.push_back(cyc);
      if (adj_min)  amin_log.push_back(cyc);
      if (adj_hour) ahour_log.push_back(cyc);
      if (mode !== prev_mode) mchg_log.push_back(cyc);
    end
    prev_mode = mode;
  end

  task automatic clear_logs();
    tick_log.delete(); clr_log.delete(); amin_log.delete(); ahour_log.delete(); mchg_log.delete();
  endtask

  // ---------------- driver ----------------
  // Hold one key for 'hold' cycles, release it, then wait out the release debounce.
  task automatic press(input int which, input int hold, output int s);
    if (which == 0) key_mode = 1'b1; else key_inc = 1'b1;
    s = cyc;
    repeat (hold) @(negedge clk);
    key_mode = 1'b0;
    key_inc  = 1'b0;
    repeat (DC + 6) @(negedge clk);
  endtask

  initial begin : watchdog
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  // Press accepted DC+2 edges after first sampling; registered outputs one edge later.
  localparam int LAT = DC + 3;

  initial begin : main
    int s, r;
    int rep_off[5];
    bit blink_pat[12];
    rep_off   = '{0, 20, 25, 30, 35};
    blink_pat = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    r = cyc;
    check("reset_mode", mode, 0);
    check("reset_outs", {tick_1hz, sec_clr, adj_min, adj_hour, blink}, 0);

    // 1: free-running ticks
    clear_logs();
    repeat (35) @(negedge clk);
    check("t1_tick_count", tick_log.size(), 3);
    for (int i = 0; i < tick_log.size() && i < 3; i++) check("t1_tick_at", tick_log[i] - r, 10 * (i + 1));
    check("t1_mode", mode, 0);
    check("t1_blink", blink, 0);

    // 2: bouncy mode key then stable high
    clear_logs();
    for (int i = 0; i < 6; i++) begin
      key_mode = (i % 2 == 0);
      @(negedge clk);
    end
    key_mode = 1'b1;
    s = cyc;
    repeat (8) @(negedge clk);
    key_mode = 1'b0;
    repeat (12) @(negedge clk);
    check("t2_mode", mode, 1);
    check("t2_mode_changes", mchg_log.size(), 1);
    if (mchg_log.size() > 0) check("t2_mode_change_at", mchg_log[0] - s, LAT);
    check("t2_clr_count", clr_log.size(), 1);
    if (clr_log.size() > 0) check("t2_clr_at", clr_log[0] - s, LAT);
    begin
      int late = 0;
      foreach (tick_log[i]) if (tick_log[i] > s + LAT) late++;
      check("t2_tick_stopped", late, 0);
    end

    // 3: single hour then minute adjust
    clear_logs();
    press(1, 4, s);
    check("t3_hour_count", ahour_log.size(), 1);
    if (ahour_log.size() > 0) check("t3_hour_at", ahour_log[0] - s, LAT);
    check("t3_min_none", amin_log.size(), 0);
    press(0, 6, s);
    check("t3_mode2", mode, 2);
    clear_logs();
    press(1, 4, s);
    check("t3_min_count", amin_log.size(), 1);
    if (amin_log.size() > 0) check("t3_min_at", amin_log[0] - s, LAT);
    check("t3_hour_none", ahour_log.size(), 0);

    // 4: auto-repeat on minutes
    clear_logs();
    press(1, 40, s);
    repeat (20) @(negedge clk);
    check("t4_min_count", amin_log.size(), 5);
    for (int i = 0; i < amin_log.size() && i < 5; i++)
      check("t4_min_offset", amin_log[i] - s - LAT, rep_off[i]);
    check("t4_hour_none", ahour_log.size(), 0);

    // 5: simultaneous mode and inc press in SET_HOUR
    press(0, 6, s);
    check("t5_run", mode, 0);
    press(0, 6, s);
    check("t5_set_hour", mode, 1);
    clear_logs();
    key_mode = 1'b1;
    key_inc  = 1'b1;
    s = cyc;
    repeat (LAT) @(negedge clk);
    check("t5_mode2", mode, 2);
    for (int j = 0; j < 12; j++) begin
      check("t5_blink", blink, blink_pat[j]);
      @(negedge clk);
    end
    key_mode = 1'b0;
    key_inc  = 1'b0;
    repeat (DC + 11) @(negedge clk);
    check("t5_no_hour", ahour_log.size(), 0);
    check("t5_no_min", amin_log.size(), 0);

    // 6: reset in the middle of an auto-repeat
    clear_logs();
    key_inc = 1'b1;
    repeat (30) @(negedge clk);
    check("t6_pre_min_count", amin_log.size(), 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    r = cyc;
    check("t6_mode", mode, 0);
    check("t6_outs", {tick_1hz, sec_clr, adj_min, adj_hour, blink}, 0);
    clear_logs();
    repeat (5) @(negedge clk);
    key_inc = 1'b0;
    repeat (15) @(negedge clk);
    check("t6_tick_seen", tick_log.size() > 0, 1);
    if (tick_log.size() > 0) check("t6_first_tick", tick_log[0] - r, 10);
    check("t6_no_adj", amin_log.size() + ahour_log.size(), 0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
